clock_time_ctrl: RTL and testbench
==================================

Name: clock_time_ctrl

Overview:
Mode and timekeeping controller for the digital clock. Sequences a two-digit BCD seconds/minutes/hours counter chain from a 1 Hz tick and runs the user time-set state machine (mode/increment buttons). Drives display digits and blink qualifiers. Sits between the debounced button front-end and the 7-segment display mux.

Parameters:
TWELVE_HR, 0, 0 = hours 00..23 (reset 00); 1 = hours 01..12 (reset 12), 12 -> 01 wrap

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
tick  in  1  1 Hz timebase, single-cycle pulse
btn_mode  in  1  debounced single-cycle pulse: advance mode
btn_inc  in  1  debounced single-cycle pulse: increment selected field
hr_bcd  out  8  hours, {tens, units} BCD
min_bcd  out  8  minutes BCD
sec_bcd  out  8  seconds BCD
mode  out  3  current state encoding
blink_hr  out  1  high = blank hour digits this phase
blink_min  out  1  high = blank minute digits this phase
alarm_hit  out  1  alarm pulse (present only with ALARM_EN)

Behaviour:
- Reset (rst = 0 at clk edge): state RUN, sec 00, min 00, hr 00 (12 if TWELVE_HR), blink phase 0, all pulse outputs 0. Reset has priority over all inputs and can occur in any state.
- States: RUN = 0, SET_HR = 1, SET_MIN = 2 (SET_AHR = 3, SET_AMIN = 4 with ALARM_EN).
- btn_mode advances RUN -> SET_HR -> SET_MIN -> RUN. With ALARM_EN the sequence is SET_MIN -> SET_AHR -> SET_AMIN -> RUN.
- RUN:
  - tick increments sec, 59 -> 00 with carry to min.
  - min 59 -> 00 carries to hr; hr 23 -> 00 (or 12 -> 01).
  - The full carry chain resolves in one cycle: outputs update the cycle after tick.
  - btn_inc is ignored.
- SET_HR:
  - tick does not advance time and sec is frozen.
  - btn_inc increments hr with wrap and no carry.
- SET_MIN:
  - btn_inc increments min, 59 -> 00, with no carry to hr.
  - Exiting to RUN (or to SET_AHR) clears sec to 00 on the same edge.
- btn_mode and btn_inc in the same cycle: the mode transition wins and the increment is dropped.
- tick and btn_mode in the same cycle while in RUN: the tick is applied and the state moves to SET_HR on the same edge.
- Blink:
  - The phase register toggles on every tick while in any SET state and is cleared to 0 on entry to RUN.
  - blink_hr = phase & (state is SET_HR or SET_AHR).
  - blink_min = phase & (state is SET_MIN or SET_AMIN).
- Digit registers only ever hold legal BCD. Units 0..9; tens 0..5 for min/sec, 0..2 (or 0..1) for hr.
- mode output is registered state, zero-extended to 3 bits.

Optional Feature:
Macro CLOCK_ALARM_EN.
- Defined:
  - Adds alarm hour/minute registers; reset 00:00 (12:00 if TWELVE_HR).
  - Adds states SET_AHR/SET_AMIN, which edit the alarm fields with the same rules as SET_HR/SET_MIN.
  - In SET_AHR/SET_AMIN, hr_bcd/min_bcd display the alarm fields and sec_bcd shows 00.
  - alarm_hit: one-cycle pulse, registered, in the cycle after a RUN tick that makes the time equal alarm hh:mm:00.
- Undefined:
  - No alarm registers and no alarm states.
  - The alarm_hit port is absent.
  - SET_MIN returns directly to RUN.

Decomposition:
- Package clock_pkg holds:
  - the state enum (RUN..SET_AMIN, 3-bit);
  - BCD limit constants (SEC_MAX = 8'h59, MIN_MAX = 8'h59, HR24_MAX = 8'h23, HR12_MAX = 8'h12, HR12_MIN = 8'h01).
- Sub-module bcd2_mod_cnt: two-digit BCD modulo counter.
  - Parameters: MAX_VAL, MIN_VAL, RST_VAL.
  - Inputs: inc and clr.
  - Outputs: value and a combinational carry (inc & value == MAX_VAL).
  - Instantiated for sec, min and hr, plus the alarm fields under the macro.

Test Plan:
1. rst = 0 for 1 cycle mid-count, then release -> time 00:00:00, mode 0, blink_hr/blink_min 0.
2. Set time to 23:59, return to RUN (sec = 00), apply 59 ticks -> 23:59:59; one more tick -> 00:00:00 on the next cycle.
3. btn_mode once, then btn_inc x25 -> hr 01 with min unchanged; ticks during SET_HR leave sec unchanged and toggle blink_hr.
4. In SET_MIN with sec = 37, assert btn_mode and btn_inc together -> mode 0, min unchanged, sec 00.
5. TWELVE_HR = 1, set hr to 12, btn_inc -> 01; run from 12:59:59 plus 1 tick -> 01:00:00.
6. CLOCK_ALARM_EN: set alarm 00:01, time 00:00:59, tick -> exactly one alarm_hit pulse with time 00:01:00; the next tick gives no pulse.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and BCD limits for the digital clock timekeeping controller.
package clock_pkg;

    localparam int unsigned BCD_W   = 8;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN      = 3'd0,
        ST_SET_HR   = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_SET_AHR  = 3'd3,
        ST_SET_AMIN = 3'd4
    } state_e;

    localparam logic [BCD_W-1:0] SEC_MAX  = 8'h59;
    localparam logic [BCD_W-1:0] MIN_MAX  = 8'h59;
    localparam logic [BCD_W-1:0] HR24_MAX = 8'h23;
    localparam logic [BCD_W-1:0] HR12_MAX = 8'h12;
    localparam logic [BCD_W-1:0] HR12_MIN = 8'h01;
    localparam logic [BCD_W-1:0] BCD_ZERO = 8'h00;

    // Next value of a two-digit BCD field that wraps from max_v back to min_v.
    function automatic logic [BCD_W-1:0] bcd_inc(
        input logic [BCD_W-1:0] v,
        input logic [BCD_W-1:0] max_v,
        input logic [BCD_W-1:0] min_v
    );
        logic [3:0] tens;
        logic [3:0] units;
        tens  = v[7:4];
        units = v[3:0];
        if (v == max_v) begin
            return min_v;
        end
        if (units == 4'd9) begin
            return {tens + 4'd1, 4'd0};
        end
        return {tens, units + 4'd1};
    endfunction

endpackage

// File: rtl/bcd2_mod_cnt.sv
// Two-digit BCD modulo counter with synchronous clear and a wrap carry.
module bcd2_mod_cnt
    import clock_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX_VAL = SEC_MAX,
    parameter logic [BCD_W-1:0] MIN_VAL = BCD_ZERO,
    parameter logic [BCD_W-1:0] RST_VAL = BCD_ZERO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [BCD_W-1:0] value,
    output logic             carry_c
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            value <= RST_VAL;
        end else if (clr) begin
            value <= MIN_VAL;
        end else if (inc) begin
            value <= bcd_inc(value, MAX_VAL, MIN_VAL);
        end
    end

    assign carry_c = inc & (value == MAX_VAL);

endmodule

// File: rtl/clock_time_ctrl.sv
// Clock mode/time-set controller with BCD time chain and blink qualifiers.
// Define CLOCK_ALARM_EN to add the alarm registers, alarm set states and alarm_hit.
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned TWELVE_HR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             btn_mode,
    input  logic             btn_inc,
    output logic [BCD_W-1:0] hr_bcd,
    output logic [BCD_W-1:0] min_bcd,
    output logic [BCD_W-1:0] sec_bcd,
    output logic [2:0]       mode,
    output logic             blink_hr,
    output logic             blink_min
`ifdef CLOCK_ALARM_EN
    ,
    output logic             alarm_hit
`endif
);

    localparam logic [BCD_W-1:0] HR_MAX = (TWELVE_HR != 0) ? HR12_MAX : HR24_MAX;
    localparam logic [BCD_W-1:0] HR_MIN = (TWELVE_HR != 0) ? HR12_MIN : BCD_ZERO;
    localparam logic [BCD_W-1:0] HR_RST = (TWELVE_HR != 0) ? HR12_MAX : BCD_ZERO;

    state_e           state_q;
    state_e           state_nxt;
    logic             phase_q;
    logic             phase_nxt;
    logic             run_c;
    logic             set_hr_inc;
    logic             set_min_inc;
    logic             sec_clr;
    logic             sec_inc;
    logic             min_inc;
    logic             hr_inc;
    logic             sec_carry_c;
    logic             min_carry_c;
    logic [BCD_W-1:0] sec_q;
    logic [BCD_W-1:0] min_q;
    logic [BCD_W-1:0] hr_q;

`ifdef CLOCK_ALARM_EN
    logic             ahr_inc;
    logic             amin_inc;
    logic [BCD_W-1:0] ahr_q;
    logic [BCD_W-1:0] amin_q;
    logic [BCD_W-1:0] min_next;
    logic [BCD_W-1:0] hr_next;
    logic             alarm_match_c;
    logic             show_alarm;
`endif

    // Time chain: carries only ripple while running; set states edit fields in isolation.
    assign run_c   = (state_q == ST_RUN);
    assign sec_inc = run_c & tick;
    assign min_inc = run_c ? sec_carry_c : set_min_inc;
    assign hr_inc  = run_c ? min_carry_c : set_hr_inc;

    bcd2_mod_cnt #(.MAX_VAL(SEC_MAX), .MIN_VAL(BCD_ZERO), .RST_VAL(BCD_ZERO)) u_sec (
        .clk(clk), .rst(rst), .inc(sec_inc), .clr(sec_clr),
        .value(sec_q), .carry_c(sec_carry_c)
    );

    bcd2_mod_cnt #(.MAX_VAL(MIN_MAX), .MIN_VAL(BCD_ZERO), .RST_VAL(BCD_ZERO)) u_min (
        .clk(clk), .rst(rst), .inc(min_inc), .clr(1'b0),
        .value(min_q), .carry_c(min_carry_c)
    );

    bcd2_mod_cnt #(.MAX_VAL(HR_MAX), .MIN_VAL(HR_MIN), .RST_VAL(HR_RST)) u_hr (
        .clk(clk), .rst(rst), .inc(hr_inc), .clr(1'b0),
        .value(hr_q), .carry_c()
    );

`ifdef CLOCK_ALARM_EN
    bcd2_mod_cnt #(.MAX_VAL(HR_MAX), .MIN_VAL(HR_MIN), .RST_VAL(HR_RST)) u_ahr (
        .clk(clk), .rst(rst), .inc(ahr_inc), .clr(1'b0),
        .value(ahr_q), .carry_c()
    );

    bcd2_mod_cnt #(.MAX_VAL(MIN_MAX), .MIN_VAL(BCD_ZERO), .RST_VAL(BCD_ZERO)) u_amin (
        .clk(clk), .rst(rst), .inc(amin_inc), .clr(1'b0),
        .value(amin_q), .carry_c()
    );

    // Alarm fires on the tick that rolls seconds 59 -> 00 into the alarm minute.
    assign min_next      = bcd_inc(min_q, MIN_MAX, BCD_ZERO);
    assign hr_next       = (min_q == MIN_MAX) ? bcd_inc(hr_q, HR_MAX, HR_MIN) : hr_q;
    assign alarm_match_c = sec_inc & (sec_q == SEC_MAX) & (min_next == amin_q) & (hr_next == ahr_q);

    assign show_alarm = (state_q == ST_SET_AHR) || (state_q == ST_SET_AMIN);
    assign hr_bcd     = show_alarm ? ahr_q : hr_q;
    assign min_bcd    = show_alarm ? amin_q : min_q;
    assign sec_bcd    = show_alarm ? BCD_ZERO : sec_q;
`else
    assign hr_bcd  = hr_q;
    assign min_bcd = min_q;
    assign sec_bcd = sec_q;
`endif

    assign mode = 3'(state_q);

    // Mode sequencing, field-edit strobes and blink phase.
    always_comb begin
        state_nxt   = state_q;
        phase_nxt   = phase_q;
        set_hr_inc  = 1'b0;
        set_min_inc = 1'b0;
        sec_clr     = 1'b0;
`ifdef CLOCK_ALARM_EN
        ahr_inc     = 1'b0;
        amin_inc    = 1'b0;
`endif
        case (state_q)
            ST_RUN: begin
                if (btn_mode) state_nxt = ST_SET_HR;
            end
            ST_SET_HR: begin
                if (btn_mode) state_nxt = ST_SET_MIN;
                else          set_hr_inc = btn_inc;
            end
            ST_SET_MIN: begin
                if (btn_mode) begin
                    sec_clr = 1'b1;
`ifdef CLOCK_ALARM_EN
                    state_nxt = ST_SET_AHR;
`else
                    state_nxt = ST_RUN;
`endif
                end else begin
                    set_min_inc = btn_inc;
                end
            end
`ifdef CLOCK_ALARM_EN
            ST_SET_AHR: begin
                if (btn_mode) state_nxt = ST_SET_AMIN;
                else          ahr_inc = btn_inc;
            end
            ST_SET_AMIN: begin
                if (btn_mode) state_nxt = ST_RUN;
                else          amin_inc = btn_inc;
            end
`endif
            default: state_nxt = ST_RUN;
        endcase
        if (!run_c) phase_nxt = phase_q ^ tick;
        if (state_nxt == ST_RUN) phase_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            phase_q   <= 1'b0;
            blink_hr  <= 1'b0;
            blink_min <= 1'b0;
`ifdef CLOCK_ALARM_EN
            alarm_hit <= 1'b0;
`endif
        end else begin
            state_q   <= state_nxt;
            phase_q   <= phase_nxt;
            blink_hr  <= phase_nxt & ((state_nxt == ST_SET_HR) || (state_nxt == ST_SET_AHR));
            blink_min <= phase_nxt & ((state_nxt == ST_SET_MIN) || (state_nxt == ST_SET_AMIN));
`ifdef CLOCK_ALARM_EN
            alarm_hit <= alarm_match_c;
`endif
        end
    end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Scoreboard bench for clock_time_ctrl: decimal reference model plus fixed checkpoints.
module tb_clock_time_ctrl;

`ifdef CLOCK_ALARM_EN
    localparam bit ALARM = 1'b1;
`else
    localparam bit ALARM = 1'b0;
`endif
    localparam int EXITS = ALARM ? 3 : 1;

    typedef struct packed {
        logic [7:0] hr;
        logic [7:0] mn;
        logic [7:0] sc;
        logic [2:0] md;
        logic       bh;
        logic       bm;
    } snap_t;

    typedef struct packed {
        logic t;
        logic m;
        logic i;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
    logic [7:0] hr_bcd, min_bcd, sec_bcd;
    logic [2:0] mode;
    logic       blink_hr, blink_min;
    logic       tick12 = 1'b0, mode12 = 1'b0, inc12 = 1'b0;
    logic [7:0] hr_12, min_12, sec_12;
    logic [2:0] mode_12;
    logic       bh_12, bm_12;
`ifdef CLOCK_ALARM_EN
    logic       alarm_hit, alarm_hit_12;
`endif

    always #5 clk = ~clk;

    clock_time_ctrl #(.TWELVE_HR(0)) dut (
        .clk(clk), .rst(rst), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .hr_bcd(hr_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd), .mode(mode),
        .blink_hr(blink_hr), .blink_min(blink_min)
`ifdef CLOCK_ALARM_EN
        , .alarm_hit(alarm_hit)
`endif
    );

    clock_time_ctrl #(.TWELVE_HR(1)) dut12 (
        .clk(clk), .rst(rst), .tick(tick12), .btn_mode(mode12), .btn_inc(inc12),
        .hr_bcd(hr_12), .min_bcd(min_12), .sec_bcd(sec_12), .mode(mode_12),
        .blink_hr(bh_12), .blink_min(bm_12)
`ifdef CLOCK_ALARM_EN
        , .alarm_hit(alarm_hit_12)
`endif
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    snap_t sb[$];
    snap_t sb12[$];
    bit    hit_q[$];
    stim_t stim[$];

    // Reference model in plain decimal
    int mh, mm, ms, mst, mah, mam;
    bit mph, mhit;

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic void model_reset();
        mh = 0; mm = 0; ms = 0; mst = 0; mph = 1'b0; mah = 0; mam = 0; mhit = 1'b0;
    endfunction

    function automatic void model_step(input bit t, input bit m, input bit i);
        int old = mst;
        mhit = 1'b0;
        case (old)
            0: begin
                if (t) begin
                    ms = ms + 1;
                    if (ms == 60) begin
                        ms = 0; mm = mm + 1;
                        if (mm == 60) begin mm = 0; mh = (mh + 1) % 24; end
                    end
                    mhit = ALARM && ms == 0 && mm == mam && mh == mah;
                end
                if (m) mst = 1;
            end
            1: if (m) mst = 2; else if (i) mh = (mh + 1) % 24;
            2: if (m) begin ms = 0; mst = ALARM ? 3 : 0; end else if (i) mm = (mm + 1) % 60;
            3: if (m) mst = 4; else if (i) mah = (mah + 1) % 24;
            default: if (m) mst = 0; else if (i) mam = (mam + 1) % 60;
        endcase
        if (old != 0 && t) mph = ~mph;
        if (mst == 0) mph = 1'b0;
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        bit al = (mst == 3 || mst == 4);
        s.hr = bcd(al ? mah : mh);
        s.mn = bcd(al ? mam : mm);
        s.sc = al ? 8'h00 : bcd(ms);
        s.md = 3'(mst);
        s.bh = mph && (mst == 1 || mst == 3);
        s.bm = mph && (mst == 2 || mst == 4);
        return s;
    endfunction

    function automatic snap_t snap();
        return {hr_bcd, min_bcd, sec_bcd, mode, blink_hr, blink_min};
    endfunction

    function automatic snap_t snap12();
        return {hr_12, min_12, sec_12, mode_12, bh_12, bm_12};
    endfunction

    task automatic add(input bit t, input bit m, input bit i, input int n);
        repeat (n) stim.push_back({t, m, i});
    endtask

    task automatic step(input bit t, input bit m, input bit i);
        tick = t; btn_mode = m; btn_inc = i;
        model_step(t, m, i);
        sb.push_back(model_snap());
        hit_q.push_back(mhit);
        @(posedge clk); #1;
        tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    endtask

    task automatic step12(input bit t, input bit m, input bit i);
        tick12 = t; mode12 = m; inc12 = i;
        @(posedge clk); #1;
        tick12 = 1'b0; mode12 = 1'b0; inc12 = 1'b0;
    endtask

    task automatic test_reset();
        snap_t e, e12;
        stim_t s;
        bit    h;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        e   = {8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        e12 = {8'h12, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        n_checks++;
        if (snap() !== e) begin n_fail++; $display("FAIL reset_24h: got %h need %h", snap(), e); end
        n_checks++;
        if (snap12() !== e12) begin n_fail++; $display("FAIL reset_12h: got %h need %h", snap12(), e12); end
        rst = 1'b1;
        add(1'b1, 1'b0, 1'b0, 7);
        while (stim.size() > 0) begin
            s = stim.pop_front(); step(s.t, s.m, s.i);
            e = sb.pop_front(); h = hit_q.pop_front(); n_checks++;
            if (snap() !== e) begin n_fail++; $display("FAIL reset_count: got %h need %h", snap(), e); end
        end
        rst = 1'b0; tick = 1'b1; btn_mode = 1'b1; btn_inc = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        model_reset();
        e = {8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        n_checks++;
        if (snap() !== e) begin n_fail++; $display("FAIL reset_midcount: got %h need %h", snap(), e); end
    endtask

    task automatic test_rollover();
        snap_t e;
        stim_t s;
        bit    h;
        add(1'b0, 1'b1, 1'b0, 1);
        add(1'b0, 1'b0, 1'b1, 23);
        add(1'b0, 1'b1, 1'b0, 1);
        add(1'b0, 1'b0, 1'b1, 59);
        add(1'b0, 1'b1, 1'b0, EXITS);
        add(1'b1, 1'b0, 1'b0, 59);
        while (stim.size() > 0) begin
            s = stim.pop_front(); step(s.t, s.m, s.i);
            e = sb.pop_front(); h = hit_q.pop_front(); n_checks++;
            if (snap() !== e) begin n_fail++; $display("FAIL rollover_seq: got %h need %h", snap(), e); end
        end
        e = {8'h23, 8'h59, 8'h59, 3'd0, 1'b0, 1'b0};
        n_checks++;
        if (snap() !== e) begin n_fail++; $display("FAIL rollover_235959: got %h need %h", snap(), e); end
        step(1'b1, 1'b0, 1'b0);
        void'(sb.pop_front()); void'(hit_q.pop_front());
        e = {8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        n_checks++;
        if (snap() !== e) begin n_fail++; $display("FAIL rollover_wrap: got %h need %h", snap(), e); end
    endtask

    task automatic test_set_hr();
        snap_t e;
        stim_t s;
        bit    h;
        add(1'b1, 1'b0, 1'b0, 3);
        add(1'b0, 1'b1, 1'b0, 1);
        for (int k = 0; k < 25; k++) add(k % 5 == 0, 1'b0, 1'b1, 1);
        while (stim.size() > 0) begin
            s = stim.pop_front(); step(s.t, s.m, s.i);
            e = sb.pop_front(); h = hit_q.pop_front(); n_checks++;
            if (snap() !== e) begin n_fail++; $display("FAIL set_hr_seq: got %h need %h", snap(), e); end
        end
        e = {8'h01, 8'h00, 8'h03, 3'd1, 1'b1, 1'b0};
        n_checks++;
        if (snap() !== e) begin n_fail++; $display("FAIL set_hr_wrap: got %h need %h", snap(), e); end
        step(1'b1, 1'b0, 1'b0);
        void'(sb.pop_front()); void'(hit_q.pop_front());
        e = {8'h01, 8'h00, 8'h03, 3'd1, 1'b0, 1'b0};
        n_checks++;
        if (snap() !== e) begin n_fail++; $display("FAIL set_hr_blink: got %h need %h", snap(), e); end
    endtask

    task automatic test_mode_inc_same_cycle();
        snap_t e;
        stim_t s;
        bit    h;
        add(1'b0, 1'b1, 1'b0, 1);
        add(1'b0, 1'b1, 1'b0, EXITS);
        add(1'b1, 1'b0, 1'b0, 37);
        add(1'b0, 1'b1, 1'b0, 2);
        add(1'b0, 1'b1, 1'b1, 1);
        while (stim.size() > 0) begin
            s = stim.pop_front(); step(s.t, s.m, s.i);
            e = sb.pop_front(); h = hit_q.pop_front(); n_checks++;
            if (snap() !== e) begin n_fail++; $display("FAIL mode_inc_seq: got %h need %h", snap(), e); end
        end
        e = {ALARM ? 8'h00 : 8'h01, 8'h00, 8'h00, ALARM ? 3'd3 : 3'd0, 1'b0, 1'b0};
        n_checks++;
        if (snap() !== e) begin n_fail++; $display("FAIL mode_inc_exit: got %h need %h", snap(), e); end
        add(1'b0, 1'b1, 1'b0, ALARM ? 2 : 0);
        while (stim.size() > 0) begin
            s = stim.pop_front(); step(s.t, s.m, s.i);
            void'(sb.pop_front()); void'(hit_q.pop_front());
        end
        e = {8'h01, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        n_checks++;
        if (snap() !== e) begin n_fail++; $display("FAIL mode_inc_run: got %h need %h", snap(), e); end
    endtask

    task automatic test_back_to_back();
        snap_t e;
        stim_t s;
        bit    h;
        step(1'b1, 1'b1, 1'b0);
        void'(sb.pop_front()); void'(hit_q.pop_front());
        e = {8'h01, 8'h00, 8'h01, 3'd1, 1'b0, 1'b0};
        n_checks++;
        if (snap() !== e) begin n_fail++; $display("FAIL tick_mode_run: got %h need %h", snap(), e); end
        step(1'b1, 1'b1, 1'b0);
        void'(sb.pop_front()); void'(hit_q.pop_front());
        e = {8'h01, 8'h00, 8'h01, 3'd2, 1'b0, 1'b1};
        n_checks++;
        if (snap() !== e) begin n_fail++; $display("FAIL tick_mode_sethr: got %h need %h", snap(), e); end
        add(1'b0, 1'b0, 1'b1, 60);
        while (stim.size() > 0) begin
            s = stim.pop_front(); step(s.t, s.m, s.i);
            e = sb.pop_front(); h = hit_q.pop_front(); n_checks++;
            if (snap() !== e) begin n_fail++; $display("FAIL min_wrap_seq: got %h need %h", snap(), e); end
        end
        e = {8'h01, 8'h00, 8'h01, 3'd2, 1'b0, 1'b1};
        n_checks++;
        if (snap() !== e) begin n_fail++; $display("FAIL min_wrap_nocarry: got %h need %h", snap(), e); end
        add(1'b0, 1'b1, 1'b0, EXITS);
        add(1'b0, 1'b0, 1'b1, 3);
        while (stim.size() > 0) begin
            s = stim.pop_front(); step(s.t, s.m, s.i);
            e = sb.pop_front(); h = hit_q.pop_front(); n_checks++;
            if (snap() !== e) begin n_fail++; $display("FAIL run_inc_seq: got %h need %h", snap(), e); end
        end
        e = {8'h01, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        n_checks++;
        if (snap() !== e) begin n_fail++; $display("FAIL run_inc_ignored: got %h need %h", snap(), e); end
    endtask

    task automatic test_twelve_hr();
        snap_t e;
        step12(1'b0, 1'b1, 1'b0);
        sb12.push_back({8'h01, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0});
        step12(1'b0, 1'b0, 1'b1);
        e = sb12.pop_front(); n_checks++;
        if (snap12() !== e) begin n_fail++; $display("FAIL hr12_wrap: got %h need %h", snap12(), e); end
        repeat (11) step12(1'b0, 1'b0, 1'b1);
        step12(1'b0, 1'b1, 1'b0);
        sb12.push_back({8'h12, 8'h59, 8'h00, 3'd2, 1'b0, 1'b0});
        repeat (59) step12(1'b0, 1'b0, 1'b1);
        e = sb12.pop_front(); n_checks++;
        if (snap12() !== e) begin n_fail++; $display("FAIL hr12_set: got %h need %h", snap12(), e); end
        repeat (EXITS) step12(1'b0, 1'b1, 1'b0);
        sb12.push_back({8'h12, 8'h59, 8'h59, 3'd0, 1'b0, 1'b0});
        repeat (59) step12(1'b1, 1'b0, 1'b0);
        e = sb12.pop_front(); n_checks++;
        if (snap12() !== e) begin n_fail++; $display("FAIL hr12_125959: got %h need %h", snap12(), e); end
        sb12.push_back({8'h01, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0});
        step12(1'b1, 1'b0, 1'b0);
        e = sb12.pop_front(); n_checks++;
        if (snap12() !== e) begin n_fail++; $display("FAIL hr12_rollover: got %h need %h", snap12(), e); end
    endtask

`ifdef CLOCK_ALARM_EN
    task automatic test_alarm();
        snap_t e;
        stim_t s;
        bit    h;
        add(1'b0, 1'b1, 1'b0, 1);
        add(1'b0, 1'b0, 1'b1, (24 - mh) % 24);
        add(1'b0, 1'b1, 1'b0, 1);
        add(1'b0, 1'b0, 1'b1, (60 - mm) % 60);
        add(1'b0, 1'b1, 1'b0, 1);
        add(1'b0, 1'b0, 1'b1, (24 - mah) % 24);
        add(1'b0, 1'b1, 1'b0, 1);
        add(1'b0, 1'b0, 1'b1, (61 - mam) % 60);
        add(1'b0, 1'b1, 1'b0, 1);
        add(1'b1, 1'b0, 1'b0, 59);
        while (stim.size() > 0) begin
            s = stim.pop_front(); step(s.t, s.m, s.i);
            e = sb.pop_front(); h = hit_q.pop_front(); n_checks++;
            if (snap() !== e || alarm_hit !== h) begin
                n_fail++;
                $display("FAIL alarm_seq: got %h hit %b need %h hit %b", snap(), alarm_hit, e, h);
            end
        end
        e = {8'h00, 8'h00, 8'h59, 3'd0, 1'b0, 1'b0};
        n_checks++;
        if (snap() !== e) begin n_fail++; $display("FAIL alarm_pre: got %h need %h", snap(), e); end
        step(1'b1, 1'b0, 1'b0);
        void'(sb.pop_front()); void'(hit_q.pop_front());
        e = {8'h00, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0};
        n_checks++;
        if (snap() !== e || alarm_hit !== 1'b1) begin
            n_fail++; $display("FAIL alarm_fire: got %h hit %b need %h hit 1", snap(), alarm_hit, e);
        end
        step(1'b0, 1'b0, 1'b0);
        void'(sb.pop_front()); void'(hit_q.pop_front());
        n_checks++;
        if (alarm_hit !== 1'b0) begin n_fail++; $display("FAIL alarm_width: got %b need 0", alarm_hit); end
        step(1'b1, 1'b0, 1'b0);
        void'(sb.pop_front()); void'(hit_q.pop_front());
        e = {8'h00, 8'h01, 8'h01, 3'd0, 1'b0, 1'b0};
        n_checks++;
        if (snap() !== e || alarm_hit !== 1'b0) begin
            n_fail++; $display("FAIL alarm_next_tick: got %h hit %b need %h hit 0", snap(), alarm_hit, e);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rollover();
        test_set_hr();
        test_mode_inc_same_cycle();
        test_back_to_back();
        test_twelve_hr();
`ifdef CLOCK_ALARM_EN
        test_alarm();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
